// File: rtl/grf_wb_scheduler_pkg.sv
// Shared CPU parameters and the write-back entry payload used by the
// GRF write-back scheduler and its result buffer.
package grf_wb_scheduler_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PEND_W   = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_scheduler_wb_fifo.sv
// First-word-fall-through buffer for multiply/divide results waiting for
// a free register-file write slot.
module wb_fifo
  import grf_wb_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      empty,
  output logic      full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; power-of-two depth makes wrap implicit.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/grf_wb_scheduler.sv
// Arbitrates the single GRF write port between the W-stage and buffered
// multiply/divide results, and tracks outstanding MD destinations for stalls.
module grf_wb_scheduler
  import grf_wb_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic [DATA_W-1:0] pipe_pc,
  input  logic              md_issue,
  input  logic [ADDR_W-1:0] md_issue_addr,
  input  logic              md_done_valid,
  input  logic [ADDR_W-1:0] md_done_addr,
  input  logic [DATA_W-1:0] md_done_data,
  input  logic [DATA_W-1:0] md_done_pc,
  output logic              md_done_ready,
  input  logic [ADDR_W-1:0] dec_rs,
  input  logic [ADDR_W-1:0] dec_rt,
  input  logic [ADDR_W-1:0] dec_dst,
  output logic              stall,
  output logic              grf_we,
  output logic [ADDR_W-1:0] grf_addr,
  output logic [DATA_W-1:0] grf_data,
  output logic [DATA_W-1:0] grf_pc
);

  wb_entry_t         md_entry;
  wb_entry_t         fifo_head;
  logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic              pipe_wr, md_accept, md_thru;
  logic              md_wr;
  logic [ADDR_W-1:0] md_wr_addr;
  logic              issue_ok;
  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [PEND_W-1:0] pend_d [NUM_REGS];

  assign md_entry = '{addr: md_done_addr, data: md_done_data, pc: md_done_pc};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(md_entry),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Write-port arbitration: pipeline first, then buffer head, then bypass.
  always_comb begin
    grf_we        = 1'b0;
    grf_addr      = '0;
    grf_data      = '0;
    grf_pc        = '0;
    fifo_pop      = 1'b0;
    md_wr         = 1'b0;
    md_wr_addr    = '0;
    pipe_wr       = pipe_we && (pipe_addr != '0);
    md_done_ready = !reset && (!fifo_full || (fifo_empty && !pipe_wr));
    md_accept     = md_done_valid && md_done_ready;
    md_thru       = md_accept && fifo_empty && !pipe_wr;
    // Register-0 results are consumed here and never take a buffer slot.
    fifo_push     = md_accept && !md_thru && (md_done_addr != '0);
    if (reset) begin
      fifo_push = 1'b0;
    end else if (pipe_wr) begin
      grf_we   = 1'b1;
      grf_addr = pipe_addr;
      grf_data = pipe_data;
      grf_pc   = pipe_pc;
    end else if (!fifo_empty) begin
      fifo_pop   = 1'b1;
      grf_we     = 1'b1;
      grf_addr   = fifo_head.addr;
      grf_data   = fifo_head.data;
      grf_pc     = fifo_head.pc;
      md_wr      = 1'b1;
      md_wr_addr = fifo_head.addr;
    end else if (md_thru && (md_done_addr != '0)) begin
      grf_we     = 1'b1;
      grf_addr   = md_done_addr;
      grf_data   = md_done_data;
      grf_pc     = md_done_pc;
      md_wr      = 1'b1;
      md_wr_addr = md_done_addr;
    end
  end

  // Hazard detection; register 0 carries no pending count so never stalls.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      stall = (pend_q[dec_rs]  != '0) ||
              (pend_q[dec_rt]  != '0) ||
              (pend_q[dec_dst] != '0) ||
              (md_issue && (pend_q[md_issue_addr] == '1));
    end
  end

  always_comb begin
    issue_ok = md_issue && !stall && (md_issue_addr != '0);
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = pend_q[r];
      if (r != 0) begin
        if ((issue_ok && (md_issue_addr == ADDR_W'(r))) &&
            !(md_wr && (md_wr_addr == ADDR_W'(r)) && (pend_q[r] != '0))) begin
          pend_d[r] = pend_q[r] + PEND_W'(1);
        end else if (!(issue_ok && (md_issue_addr == ADDR_W'(r))) &&
                     (md_wr && (md_wr_addr == ADDR_W'(r)) && (pend_q[r] != '0))) begin
          pend_d[r] = pend_q[r] - PEND_W'(1);
        end
      end else begin
        pend_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (reset) begin
        pend_q[r] <= '0;
      end else begin
        pend_q[r] <= pend_d[r];
      end
    end
  end

endmodule
